// File: rtl/bleuart_rx.sv
`default_nettype none
// ============================================================================
// Module      : bleuart_rx
// Description : 8N1 UART receiver for the BLE module serial link.
//               The rx line is double-flop synchronized, a start bit is
//               qualified at its mid-point, and eight data bits (LSB first)
//               plus the stop bit are sampled once per bit period.
//               Completed bytes land in a single-entry holding register
//               with a valid/ready handshake toward the consumer.
//               Framing errors and overruns raise a one-cycle error pulse.
//
// Ports       : clk           system clock, rising edge
//               rst           synchronous, active-high reset
//               rx            asynchronous serial input, idle high
//               enable        gates acceptance of new frames only
//               data_out[7:0] received byte, valid while data_valid is high
//               data_valid    holding register full
//               data_ready    consumer takes data_out when valid & ready
//               uart_in_error one-cycle pulse on framing error or overrun
//               busy          receiver is somewhere other than IDLE
//
// Revision    : 1.0  initial release
// ============================================================================
module bleuart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       uart_in_error,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Mid-bit point used to qualify the start bit, and the last count of a
    // full bit period.
    localparam logic [CW-1:0] c_cnt_half = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] c_cnt_last = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rx_m;
    logic            r_rx_s;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;

    logic            w_byte_done;
    logic            w_frame_err;

    logic [7:0]      r_data_out;
    logic            r_data_valid;
    logic            r_err;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle (high) line level so
    // that reset never manufactures a false start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The baud counter free-runs inside a state and is
    // forced back to zero whenever a sample is taken or the state changes,
    // so it never climbs past the last count of a bit period.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_done   = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable && !r_rx_s) begin
                    w_state_nxt   = S_START;
                    w_bit_idx_nxt = 3'd0;
                end
            end

            S_START: begin
                if (r_cnt == c_cnt_half) begin
                    w_cnt_nxt = '0;
                    // A line that is high again at mid-start was a glitch.
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = r_rx_s;
                    w_bit_idx_nxt          = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // Hold off through a break so it reports only one error.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and error pulse. A completed byte is accepted when
    // the register is empty or is being drained in the same cycle;
    // otherwise it is an overrun and the held byte is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_frame_err | (w_byte_done & r_data_valid & ~data_ready);
            if (w_byte_done && (!r_data_valid || data_ready)) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;
    assign uart_in_error = r_err;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bleuart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bleuart_rx
// Description : Directed self-checking bench for bleuart_rx at 16 clocks
//               per bit. Each scenario task drives the serial line and
//               checks outputs and monitor counters against hand-computed
//               values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bleuart_rx;

    localparam int CPB = 16;
    // Cycles from driving the start edge to data_valid / error being seen:
    // 2 sync + 1 IDLE detect + CPB/2 + 9*CPB + 1 register stage.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       uart_in_error;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;

    int cyc = 0;
    int t_start = 0;
    int n_vcyc = 0;
    int n_acc = 0;
    int n_err = 0;
    int v_rise = 0;
    int e_rise = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic err_consec = 1'b0;
    logic [7:0] acc_log [0:63];

    bleuart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .enable        (enable),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .uart_in_error (uart_in_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation monitor, sampled mid-low-phase after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (data_valid === 1'b1) begin
            n_vcyc++;
            if (!prev_v) v_rise = cyc;
        end
        if (data_valid === 1'b1 && data_ready === 1'b1) begin
            acc_log[n_acc[5:0]] = data_out;
            n_acc++;
        end
        if (uart_in_error === 1'b1) begin
            n_err++;
            if (prev_e) err_consec = 1'b1;
            if (!prev_e) e_rise = cyc;
        end
        prev_v = (data_valid === 1'b1);
        prev_e = (uart_in_error === 1'b1);
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_cmp++; if (uart_in_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", uart_in_error); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int a0, v0, e0;
        a0 = n_acc; v0 = n_vcyc; e0 = n_err;
        data_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", acc_log[a0[5:0]]); end
        n_cmp++; if (n_vcyc - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d want 1", n_vcyc - v0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL basic_err: got %0d want 0", n_err - e0); end
        n_cmp++; if (v_rise - t_start !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", v_rise - t_start, LAT); end
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = n_vcyc; e0 = n_err;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        repeat (20) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b want 0", busy); end
        n_cmp++; if (n_vcyc - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", n_vcyc - v0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_framing;
        int a0, v0, e0;
        a0 = n_acc; v0 = n_vcyc; e0 = n_err;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_break: got %b want 1", busy); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b want 0", busy); end
        n_cmp++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", n_err - e0); end
        n_cmp++; if (e_rise - t_start !== LAT) begin n_fail++; $display("FAIL frame_err_time: got %0d want %0d", e_rise - t_start, LAT); end
        n_cmp++; if (n_vcyc - v0 !== 0) begin n_fail++; $display("FAIL frame_valid: got %0d want 0", n_vcyc - v0); end
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL frame_next_count: got %0d want 1", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'h55) begin n_fail++; $display("FAIL frame_next_data: got %h want 55", acc_log[a0[5:0]]); end
    endtask

    task automatic test_overrun;
        int a0, e0;
        a0 = n_acc; e0 = n_err;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", data_valid); end
        n_cmp++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL ovr_data_held: got %h want 11", data_out); end
        n_cmp++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL ovr_err_count: got %0d want 1", n_err - e0); end
        data_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", data_valid); end
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d want 1", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_data: got %h want 11", acc_log[a0[5:0]]); end
    endtask

    task automatic test_enable;
        int a0;
        a0 = n_acc;
        enable = 1'b0;
        send_frame(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 0) begin n_fail++; $display("FAIL en_blocked: got %0d want 0", n_acc - a0); end
        enable = 1'b1;
        send_bit(1'b0);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'(8'hC3 >> i));
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL en_midframe_count: got %0d want 1", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'hC3) begin n_fail++; $display("FAIL en_midframe_data: got %h want c3", acc_log[a0[5:0]]); end
        enable = 1'b1;
    endtask

    task automatic test_reset_midframe;
        int a0, v0, e0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        v0 = n_vcyc; e0 = n_err;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_out: got %h want 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        n_cmp++; if (n_vcyc - v0 !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d want 0", n_vcyc - v0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL rstmid_no_err: got %0d want 0", n_err - e0); end
        a0 = n_acc;
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'h81) begin n_fail++; $display("FAIL rstmid_next_data: got %h want 81", acc_log[a0[5:0]]); end
    endtask

    task automatic test_back_to_back;
        int a0, v0, e0;
        a0 = n_acc; v0 = n_vcyc; e0 = n_err;
        data_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (8) @(negedge clk);
        n_cmp++; if (n_acc - a0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", n_acc - a0); end
        n_cmp++; if (acc_log[a0[5:0]] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h want 00", acc_log[a0[5:0]]); end
        n_cmp++; if (acc_log[6'(a0 + 1)] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", acc_log[6'(a0 + 1)]); end
        n_cmp++; if (n_vcyc - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d want 2", n_vcyc - v0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", n_err - e0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_enable();
        test_reset_midframe();
        test_back_to_back();
        n_cmp++; if (err_consec !== 1'b0) begin n_fail++; $display("FAIL err_two_cycles: got %b want 0", err_consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bleuart_rx.md
BLEUART_RX -- requirements
Module: bleuart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx  input  1  asynchronous serial line from BLE module, idle high, 8N1, LSB first.
REQ-005 enable  input  1  when low, no new frame is accepted; a frame already in progress completes.
REQ-006 data_out  output  8  received byte, valid while data_valid high.
REQ-007 data_valid  output  1  holding register full.
REQ-008 data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
REQ-009 uart_in_error  output  1  single-cycle pulse on framing error or overrun; drives downstream error catcher.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on enable=1 and rx_s=0 SHALL go to START with bit counter cleared; otherwise stay.
REQ-014 START: after CLKS_PER_BIT/2 (integer divide) cycles, SHALL sample rx_s; 0 -> DATA with baud counter cleared; 1 -> IDLE (glitch rejection, no error).
REQ-015 DATA: every CLKS_PER_BIT cycles SHALL sample rx_s into shift register bit index 0..7 (LSB first); after the 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; 1 -> byte complete, go IDLE; 0 -> framing error, go WAIT_IDLE.
REQ-017 WAIT_IDLE: SHALL remain until rx_s=1, then go IDLE (break condition yields exactly one error pulse).
REQ-018 Byte complete with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle: data_out SHALL load the shift register and data_valid SHALL be 1 on the next cycle.
REQ-019 Byte complete with data_valid=1 and data_ready=0: overrun; new byte discarded, data_out unchanged, uart_in_error pulsed for one cycle.
REQ-020 Framing error: shift register discarded, data_out/data_valid unchanged, uart_in_error pulsed one cycle, asserted on the cycle after the stop sample.
REQ-021 data_valid SHALL clear on the cycle after data_valid & data_ready when no byte completes in that cycle.
REQ-022 uart_in_error SHALL never be high for two consecutive cycles; framing error and overrun cannot coincide.
REQ-023 Baud counter width SHALL be clog2(CLKS_PER_BIT); counter resets to 0 on every state transition; no wrap beyond CLKS_PER_BIT-1.
REQ-024 Latency: data_valid rises exactly 1 cycle after the stop-bit sample cycle; stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the START entry cycle.
REQ-025 enable deasserted mid-frame SHALL NOT abort the frame; it only blocks the IDLE->START transition.

Reset
REQ-026 On rst: state IDLE, counters 0, shift register 0, data_out 0x00, data_valid 0, uart_in_error 0, busy 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no data_valid and no error pulse; reception resumes only at the next falling edge after rst deasserts.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0xA5 with valid stop, data_ready=1 -> data_valid one cycle, data_out=0xA5, uart_in_error never high.
REQ-029 Send 0x3C with stop bit 0, then hold rx low 40 cycles, then high -> exactly one uart_in_error pulse, data_valid stays 0, busy until rx returns high, next frame 0x55 received correctly.
REQ-030 rx low pulse of 5 cycles -> FSM returns to IDLE, no data_valid, no error.
REQ-031 data_ready=0; send 0x11 then 0x22 -> data_out=0x11 held, one uart_in_error pulse at 0x22 completion; then data_ready=1 -> data_valid drops next cycle.
REQ-032 Assert rst at bit 4 of 0xFF -> all outputs at reset values, no pulse; subsequent 0x81 received correctly.
REQ-033 Back-to-back 0x00 and 0xFF with zero idle gap, data_ready=1 -> two data_valid pulses, data_out 0x00 then 0xFF.
